// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

    // Captured request; a fetch is a 4-byte read with no write data.
    typedef struct packed {
        logic       wr;
        logic [1:0] last;
        addr_t      addr;
        word_t      wdata;
    } mem_req_t;

    // Index of the last byte of an access; the reserved code behaves as a word.
    function automatic logic [1:0] size_last(input logic [1:0] size);
        case (mem_size_e'(size))
            SIZE_BYTE: return 2'd0;
            SIZE_HALF: return 2'd1;
            default:   return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller serving the instruction fetcher and the load/store buffer.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned IO_SEL_HI = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [BYTE_W-1:0] mem_din,
    output logic [BYTE_W-1:0] mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              if_start,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_finish,
    output logic [DATA_W-1:0] if_inst,
    input  logic              lsb_start,
    input  logic              lsb_wr,
    input  logic [1:0]        lsb_size,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [DATA_W-1:0] lsb_wdata,
    output logic              lsb_finish,
    output logic [DATA_W-1:0] lsb_rdata,
    input  logic              misbranch_flag
);

    function automatic logic is_io(input addr_t a);
        return a[IO_SEL_HI -: 2] == 2'b11;
    endfunction

    state_e   state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic     prime_q, prime_d;
    logic     cur_lsb_q, cur_lsb_d;
    mem_req_t cur_q, cur_d;
    word_t    asm_q, asm_d;
    logic     if_pend_q, if_pend_d;
    addr_t    if_addr_q, if_addr_d;
    logic     lsb_pend_q, lsb_pend_d;
    mem_req_t lsb_q, lsb_d;
    addr_t    mem_a_q, mem_a_d;
    logic     mem_wr_q, mem_wr_d;
    byte_t    mem_dout_q, mem_dout_d;
    logic     if_finish_q, if_finish_d;
    word_t    if_inst_q, if_inst_d;
    logic     lsb_finish_q, lsb_finish_d;
    word_t    lsb_rdata_q, lsb_rdata_d;

    logic       launch;
    logic       wr_try;
    logic [1:0] wr_k;
    addr_t      wr_addr;

    // State and output registers; rdy gating lives in the next-state logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            prime_q      <= 1'b0;
            cur_lsb_q    <= 1'b0;
            cur_q        <= '0;
            asm_q        <= '0;
            if_pend_q    <= 1'b0;
            if_addr_q    <= '0;
            lsb_pend_q   <= 1'b0;
            lsb_q        <= '0;
            mem_a_q      <= '0;
            mem_wr_q     <= 1'b0;
            mem_dout_q   <= '0;
            if_finish_q  <= 1'b0;
            if_inst_q    <= '0;
            lsb_finish_q <= 1'b0;
            lsb_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prime_q      <= prime_d;
            cur_lsb_q    <= cur_lsb_d;
            cur_q        <= cur_d;
            asm_q        <= asm_d;
            if_pend_q    <= if_pend_d;
            if_addr_q    <= if_addr_d;
            lsb_pend_q   <= lsb_pend_d;
            lsb_q        <= lsb_d;
            mem_a_q      <= mem_a_d;
            mem_wr_q     <= mem_wr_d;
            mem_dout_q   <= mem_dout_d;
            if_finish_q  <= if_finish_d;
            if_inst_q    <= if_inst_d;
            lsb_finish_q <= lsb_finish_d;
            lsb_rdata_q  <= lsb_rdata_d;
        end
    end

    // Request capture, arbitration, byte sequencing and next output values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prime_d      = prime_q;
        cur_lsb_d    = cur_lsb_q;
        cur_d        = cur_q;
        asm_d        = asm_q;
        mem_a_d      = mem_a_q;
        mem_wr_d     = mem_wr_q;
        mem_dout_d   = mem_dout_q;
        if_finish_d  = if_finish_q;
        if_inst_d    = if_inst_q;
        lsb_finish_d = lsb_finish_q;
        lsb_rdata_d  = lsb_rdata_q;
        launch       = 1'b0;
        wr_try       = 1'b0;
        wr_k         = 2'd0;
        wr_addr      = '0;

        // Start pulses are never dropped, even while frozen.
        if_pend_d  = if_pend_q | if_start;
        if_addr_d  = if_start ? if_addr : if_addr_q;
        lsb_pend_d = lsb_pend_q | lsb_start;
        lsb_d      = lsb_start ? '{wr: lsb_wr, last: size_last(lsb_size),
                                   addr: lsb_addr, wdata: lsb_wdata} : lsb_q;

        if (rdy) begin
            if_finish_d  = 1'b0;
            lsb_finish_d = 1'b0;

            // A flush kills reads (including same-cycle pulses) but never stores.
            if (misbranch_flag) begin
                if_pend_d = 1'b0;
                if (!lsb_d.wr) begin
                    lsb_pend_d = 1'b0;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    mem_wr_d = 1'b0;
                    mem_a_d  = '0;
                    cnt_d    = 2'd0;
                    asm_d    = '0;
                    launch   = lsb_pend_d | if_pend_d;
                    if (lsb_pend_d) begin
                        cur_d      = lsb_d;
                        cur_lsb_d  = 1'b1;
                        lsb_pend_d = 1'b0;
                    end else if (if_pend_d) begin
                        cur_d     = '{wr: 1'b0, last: 2'd3, addr: if_addr_d, wdata: '0};
                        cur_lsb_d = 1'b0;
                        if_pend_d = 1'b0;
                    end
                    if (launch) begin
                        if (cur_d.wr) begin
                            state_d = ST_WRITE;
                            wr_try  = 1'b1;
                        end else begin
                            state_d = ST_READ;
                            prime_d = 1'b1;
                            mem_a_d = cur_d.addr;
                        end
                    end
                end

                ST_READ: begin
                    if (misbranch_flag) begin
                        state_d = ST_IDLE;
                        mem_a_d = '0;
                    end else if (prime_q) begin
                        // First address cycle: nothing valid on mem_din yet.
                        prime_d = 1'b0;
                        mem_a_d = (cur_q.last != 2'd0) ? cur_q.addr + 32'd1 : '0;
                    end else begin
                        asm_d = asm_q | (word_t'(mem_din) << {cnt_q, 3'b000});
                        if (cnt_q == cur_q.last) begin
                            state_d = ST_IDLE;
                            mem_a_d = '0;
                            if (cur_lsb_q) begin
                                lsb_finish_d = 1'b1;
                                lsb_rdata_d  = asm_d;
                            end else begin
                                if_finish_d = 1'b1;
                                if_inst_d   = asm_d;
                            end
                        end else begin
                            cnt_d   = cnt_q + 2'd1;
                            mem_a_d = (({1'b0, cnt_q} + 3'd2) <= {1'b0, cur_q.last})
                                      ? cur_q.addr + addr_t'(cnt_q) + 32'd2 : '0;
                        end
                    end
                end

                ST_WRITE: begin
                    // mem_wr_q high means byte cnt_q went out this cycle.
                    if (mem_wr_q) begin
                        if (cnt_q == cur_q.last) begin
                            state_d      = ST_IDLE;
                            mem_wr_d     = 1'b0;
                            mem_a_d      = '0;
                            lsb_finish_d = 1'b1;
                        end else begin
                            wr_k   = cnt_q + 2'd1;
                            wr_try = 1'b1;
                        end
                    end else begin
                        wr_k   = cnt_q;
                        wr_try = 1'b1;
                    end
                end

                default: begin
                    state_d  = ST_IDLE;
                    mem_wr_d = 1'b0;
                    mem_a_d  = '0;
                end
            endcase

            // Issue store byte wr_k, or stall while the IO buffer is full.
            if (wr_try) begin
                wr_addr = cur_d.addr + addr_t'(wr_k);
                cnt_d   = wr_k;
                if (is_io(wr_addr) && io_buffer_full) begin
                    mem_wr_d = 1'b0;
                    mem_a_d  = '0;
                end else begin
                    mem_wr_d   = 1'b1;
                    mem_a_d    = wr_addr;
                    mem_dout_d = cur_d.wdata[{wr_k, 3'b000} +: BYTE_W];
                end
            end
        end
    end

    assign mem_a      = mem_a_q;
    assign mem_wr     = mem_wr_q;
    assign mem_dout   = mem_dout_q;
    assign if_finish  = if_finish_q;
    assign if_inst    = if_inst_q;
    assign lsb_finish = lsb_finish_q;
    assign lsb_rdata  = lsb_rdata_q;

endmodule
